// File: rtl/rv32_alu_pkg.sv
// Shared RV32I ALU constants: control codes, opcodes, funct7 values
// and the decoded beat bundle passed from decode into the issue register.
package rv32_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0010,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SLTU = 4'b1000,
        ALU_SLT  = 4'b1001,
        ALU_SLL  = 4'b1100,
        ALU_SRL  = 4'b1101,
        ALU_SRA  = 4'b1110
    } alu_ctl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_ctl_e    ctl;
        logic [31:0] da;
        logic [31:0] db;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_branch;
        logic [2:0]  funct3;
        logic        illegal;
    } alu_dec_t;

    // alt selects SUB for 000 and SRA for 101
    function automatic alu_ctl_e f3_ctl(input logic [2:0] f3,
                                        input logic alt);
        case (f3)
            3'b000:  f3_ctl = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_ctl = ALU_SLL;
            3'b010:  f3_ctl = ALU_SLT;
            3'b011:  f3_ctl = ALU_SLTU;
            3'b100:  f3_ctl = ALU_XOR;
            3'b101:  f3_ctl = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_ctl = ALU_OR;
            default: f3_ctl = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU control, operands and
// writeback/branch/illegal flags for one beat.
module alu_op_decode
    import rv32_alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output alu_dec_t    dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] u_imm;
    logic        ill;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign u_imm = {instr[31:12], 12'b0};

    always_comb begin
        dec           = '0;
        dec.ctl       = ALU_ADD;
        dec.rd        = instr[11:7];
        dec.funct3    = f3;
        dec.rd_we     = 1'b1;
        ill           = 1'b0;
        unique case (1'b1)
            opc == OPC_OP: begin
                ill = !(f7 == F7_BASE ||
                        (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
                dec.ctl = f3_ctl(f3, f7 == F7_ALT);
                dec.da  = rs1_data;
                dec.db  = rs2_data;
            end
            opc == OPC_OP_IMM: begin
                if (f3 == 3'b001)
                    ill = f7 != F7_BASE;
                else if (f3 == 3'b101)
                    ill = !(f7 == F7_BASE || f7 == F7_ALT);
                dec.ctl = f3_ctl(f3, f3 == 3'b101 && f7 == F7_ALT);
                dec.da  = rs1_data;
                dec.db  = (f3[1:0] == 2'b01) ? {27'b0, instr[24:20]}
                                             : i_imm;
            end
            opc == OPC_LUI: begin
                dec.db = u_imm;
            end
            opc == OPC_AUIPC: begin
                dec.da = pc;
                dec.db = u_imm;
            end
            opc == OPC_JAL || opc == OPC_JALR: begin
                dec.da = pc;
                dec.db = 32'd4;
            end
            opc == OPC_LOAD: begin
                dec.da = rs1_data;
                dec.db = i_imm;
            end
            opc == OPC_STORE: begin
                dec.da    = rs1_data;
                dec.db    = s_imm;
                dec.rd_we = 1'b0;
            end
            opc == OPC_BRANCH: begin
                ill           = f3[2:1] == 2'b01;
                dec.ctl       = !f3[2] ? ALU_SUB :
                                (f3[1] ? ALU_SLTU : ALU_SLT);
                dec.da        = rs1_data;
                dec.db        = rs2_data;
                dec.is_branch = 1'b1;
                dec.rd_we     = 1'b0;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec.ctl       = ALU_ADD;
            dec.da        = '0;
            dec.db        = '0;
            dec.rd_we     = 1'b0;
            dec.is_branch = 1'b0;
        end
        dec.illegal = ill;
        if (dec.rd == 5'd0)
            dec.rd_we = 1'b0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: valid/ready pipeline register between decode and EX,
// holding the decoded beat stable under back-pressure.
module alu_issue_stage
    import rv32_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ALU_DA,
    output logic [31:0] ALU_DB,
    output logic [3:0]  ALU_CTL,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_is_branch,
    output logic [2:0]  out_funct3,
    output logic        out_illegal
);

    alu_dec_t dec;
    alu_dec_t q;
    logic     capture;

    alu_op_decode u_dec (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .dec      (dec)
    );

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            q         <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign ALU_DA        = q.da;
    assign ALU_DB        = q.db;
    assign ALU_CTL       = q.ctl;
    assign out_rd        = q.rd;
    assign out_rd_we     = q.rd_we;
    assign out_is_branch = q.is_branch;
    assign out_funct3    = q.funct3;
    assign out_illegal   = q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, stall, flush
// and asynchronous reset with hand-computed expectations.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALU_DA;
    logic [31:0] ALU_DB;
    logic [3:0]  ALU_CTL;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_is_branch;
    logic [2:0]  out_funct3;
    logic        out_illegal;

    int n_chk;
    int n_fail;

    alu_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_DA        (ALU_DA),
        .ALU_DB        (ALU_DB),
        .ALU_CTL       (ALU_CTL),
        .out_rd        (out_rd),
        .out_rd_we     (out_rd_we),
        .out_is_branch (out_is_branch),
        .out_funct3    (out_funct3),
        .out_illegal   (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // present one beat at negedge, hold it across one rising edge
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clk);
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] ctl,
                            input logic [31:0] da, input logic [31:0] db,
                            input logic we, input logic br,
                            input logic ill);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".ctl"},   32'(ALU_CTL), 32'(ctl));
        check({tag, ".da"},    ALU_DA, da);
        check({tag, ".db"},    ALU_DB, db);
        check({tag, ".we"},    32'(out_rd_we), 32'(we));
        check({tag, ".br"},    32'(out_is_branch), 32'(br));
        check({tag, ".ill"},   32'(out_illegal), 32'(ill));
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_pc       = '0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.ctl",   32'(ALU_CTL), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h002081B3, 32'h100, 32'd5, 32'd7);
        chk_beat("add", 4'b0000, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
        check("add.rd", 32'(out_rd), 32'd3);

        issue(32'h40435293, 32'h104, 32'h80000000, 32'd9);
        chk_beat("srai", 4'b1110, 32'h80000000, 32'd4, 1'b1, 1'b0, 1'b0);

        issue(32'h0020E063, 32'h108, 32'd1, 32'd2);
        chk_beat("bltu", 4'b1000, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
        check("bltu.f3", 32'(out_funct3), 32'd6);

        issue(32'hFFF00093, 32'h10C, 32'd10, 32'd0);
        chk_beat("addi", 4'b0000, 32'd10, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

        issue(32'h123452B7, 32'h110, 32'd3, 32'd4);
        chk_beat("lui", 4'b0000, 32'd0, 32'h12345000, 1'b1, 1'b0, 1'b0);

        issue(32'h00001317, 32'h114, 32'd3, 32'd4);
        chk_beat("auipc", 4'b0000, 32'h114, 32'h1000, 1'b1, 1'b0, 1'b0);

        issue(32'h000000EF, 32'h118, 32'd3, 32'd4);
        chk_beat("jal", 4'b0000, 32'h118, 32'd4, 1'b1, 1'b0, 1'b0);

        issue(32'hFE20AE23, 32'h11C, 32'h2000, 32'd4);
        chk_beat("sw", 4'b0000, 32'h2000, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);

        issue(32'h022081B3, 32'h120, 32'd5, 32'd7);
        chk_beat("mul_ill", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        issue(32'h402091B3, 32'h124, 32'd5, 32'd7);
        chk_beat("sllalt_ill", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        issue(32'h0020A063, 32'h128, 32'd5, 32'd7);
        chk_beat("br010_ill", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        issue(32'h40431293, 32'h12C, 32'd5, 32'd7);
        chk_beat("slli_ill", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        issue(32'h00431293, 32'h130, 32'd5, 32'd7);
        chk_beat("slli", 4'b1100, 32'd5, 32'd4, 1'b1, 1'b0, 1'b0);

        // stall: ADD held, SUB waits, then both move on one edge
        issue(32'h002081B3, 32'h200, 32'd5, 32'd7);
        @(negedge clk);
        out_ready   = 1'b0;
        in_instr    = 32'h40208233;
        in_rs1_data = 32'd9;
        in_rs2_data = 32'd3;
        in_valid    = 1'b1;
        #1;
        check("stall.in_ready", 32'(in_ready), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("stall.ctl", 32'(ALU_CTL), 32'd0);
            check("stall.db",  ALU_DB, 32'd7);
            check("stall.valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("unstall.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_beat("sub", 4'b0010, 32'd9, 32'd3, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("drain.valid", 32'(out_valid), 32'd0);

        // flush overrides a capture that would otherwise happen
        issue(32'h0000007F, 32'h300, 32'd5, 32'd7);
        chk_beat("op7f", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        in_instr    = 32'h002081B3;
        in_rs1_data = 32'd5;
        in_rs2_data = 32'd7;
        in_valid    = 1'b1;
        flush       = 1'b1;
        #1;
        check("flush.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush.valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("flush.absent", 32'(out_valid), 32'd0);

        // async reset in the middle of a stall
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h400, 32'd5, 32'd7);
        check("prerst.valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.da",    ALU_DA, 32'd0);
        check("arst.db",    ALU_DB, 32'd0);
        check("arst.ctl",   32'(ALU_CTL), 32'd0);
        check("arst.rd",    32'(out_rd), 32'd0);
        check("arst.misc",  32'({out_rd_we, out_is_branch, out_funct3,
                                 out_illegal}), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        issue(32'h00000013, 32'h500, 32'd0, 32'd0);
        chk_beat("addi_x0", 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32.
REQ-002 SHALL provide: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide: in_valid  input  1  decode-stage beat valid.
REQ-005 SHALL provide: in_ready  output  1  stage can accept beat.
REQ-006 SHALL provide: in_instr  input  32  RV32I instruction word.
REQ-007 SHALL provide: in_pc  input  32  instruction address.
REQ-008 SHALL provide: in_rs1_data / in_rs2_data  input  32 each  register-file read values.
REQ-009 SHALL provide: flush  input  1  synchronous squash of stage contents.
REQ-010 SHALL provide: out_valid  output  1  EX beat valid.
REQ-011 SHALL provide: out_ready  input  1  EX accepts beat.
REQ-012 SHALL provide: ALU_DA / ALU_DB  output  32 each  ALU operands, registered.
REQ-013 SHALL provide: ALU_CTL  output  4  ALU operation code, registered.
REQ-014 SHALL provide: out_rd  output  5, out_rd_we  output  1, out_is_branch  output  1, out_funct3  output  3, out_illegal  output  1.

Function
REQ-015 SHALL encode ALU_CTL: ADD 0000, SUB 0010, AND 0100, OR 0101, XOR 0110, SLTU 1000, SLT 1001, SLL 1100, SRL 1101, SRA 1110; overflow-flagged codes 0001/0011 never issued.
REQ-016 SHALL decode OP/OP-IMM: funct3 000 ADD (SUB when OP and funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7, 110 OR, 111 AND.
REQ-017 SHALL drive operands: OP -> DA=rs1, DB=rs2; OP-IMM -> DB=sign-extended I-imm, shifts DB={27'b0,shamt}.
REQ-018 SHALL decode LUI -> ADD, DA=0, DB={imm[31:12],12'b0}; AUIPC -> ADD, DA=pc, same DB.
REQ-019 SHALL decode JAL/JALR -> ADD, DA=pc, DB=4, rd written.
REQ-020 SHALL decode LOAD -> ADD rs1+I-imm; STORE -> ADD rs1+S-imm, rd_we=0.
REQ-021 SHALL decode BRANCH -> DA=rs1, DB=rs2, out_is_branch=1, rd_we=0; BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU.
REQ-022 SHALL set out_funct3=in_instr[14:12] for every beat.
REQ-023 SHALL flag illegal: unknown opcode, OP funct7 not 0000000/0100000, 0100000 with funct3 not 000/101, OP-IMM shift funct7 invalid, branch funct3 010/011.
REQ-024 SHALL for illegal beats issue ALU_CTL=ADD, DA=DB=0, rd_we=0, is_branch=0, out_illegal=1.
REQ-025 SHALL force out_rd_we=0 when rd=0.
REQ-026 SHALL compute in_ready = !out_valid || out_ready (combinational, also during flush).
REQ-027 SHALL capture on in_valid&&in_ready&&!flush; outputs valid next cycle (latency 1).
REQ-028 SHALL hold all out_* payload stable while out_valid&&!out_ready.
REQ-029 SHALL clear out_valid when out_valid&&out_ready and no capture the same cycle.
REQ-030 SHALL give simultaneous EX accept and new capture back-to-back throughput of one beat/cycle.
REQ-031 SHALL on flush clear out_valid next cycle and drop any beat offered that cycle, flush overriding capture.

Reset
REQ-032 SHALL on rst_n low immediately set out_valid=0, ALU_DA=ALU_DB=0, ALU_CTL=0000, out_rd=0, out_rd_we=0, out_is_branch=0, out_funct3=0, out_illegal=0.
REQ-033 SHALL drop any in-flight beat on reset mid-operation; first capture on first clk edge after rst_n release.

Structure
REQ-034 SHALL place ALU_CTL codes, RV32I opcode constants and funct7 constants in shared package rv32_alu_pkg.
REQ-035 SHALL isolate combinational decode (REQ-015..025) in sub-module alu_op_decode; the top holds only handshake and pipeline register.

Verification
REQ-036 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, CTL=0000, DA=5, DB=7, rd=3, rd_we=1.
REQ-037 SRAI x5,x6,4 (0x40435293), rs1=0x80000000 -> CTL=1110, DB=4, rd_we=1, out_illegal=0.
REQ-038 BLTU x1,x2 (0x0020E063) -> CTL=1000, out_is_branch=1, out_funct3=110, rd_we=0.
REQ-039 out_ready=0 two cycles with in_valid=1 -> in_ready=0, payload unchanged; out_ready=1 -> beat accepted, next beat captured same edge.
REQ-040 Opcode 0x7F, then flush on a cycle with out_valid=1 and in_valid=1 -> out_illegal=1/CTL=0000/DA=DB=0; after flush out_valid=0, flushed input absent.
REQ-041 rst_n low mid-stall -> all outputs zero immediately; ADDI x0,x0,0 after release -> rd_we=0.
